// File: rtl/obstacle_scheduler_pkg.sv
// Shared definitions for the obstacle scheduler.
// - RandomNumLen / RandomCount: default width of one random value and values per batch.
// - state_e: 3-bit FSM state encoding (IDLE, REQ, LOAD, WAIT, SPAWN).
// - idx_width(): width of a slice index, never less than one bit.
package obstacle_scheduler_pkg;

  localparam int unsigned RandomNumLen = 4;
  localparam int unsigned RandomCount  = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StLoad  = 3'd2,
    StWait  = 3'd3,
    StSpawn = 3'd4
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obstacle_gap_counter.sv
// Gap countdown between obstacle spawns.
// Ports:
// - clock, reset   : rising-edge clock, asynchronous active-low reset
// - clear          : synchronous clear to zero (highest priority)
// - load, load_val : load a new gap in ticks
// - tick           : qualified game tick, decrements the count
// - expire         : tick arriving while the count is 1 (the gap-th tick)
module obstacle_gap_counter #(
  parameter int unsigned GAP_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [GAP_W-1:0] cnt_q;

  assign expire = tick && (cnt_q == GAP_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - GAP_W'(1);
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: requests a batch of random values, latches it and turns each
// value into an obstacle type plus a gap (in game ticks) before that obstacle spawns.
// Ports:
// - clock, reset : rising-edge clock, asynchronous active-low reset
// - enable       : game running; low returns to idle on the next edge
// - tick         : one-cycle game-step strobe
// - randoms      : batch from the generator, slice i = randoms[i*NUM_W +: NUM_W]
// - rand_start   : one-cycle request to the generator
// - spawn        : one-cycle spawn pulse
// - spawn_type   : type of the current/last spawn, held between pulses
// - busy         : high in every state except idle
// All outputs are registered.
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int unsigned NUM_W    = RandomNumLen,
  parameter int unsigned COUNT    = RandomCount,
  parameter int unsigned TYPE_W   = 2,
  parameter int unsigned GAP_MIN  = 8,
  parameter int unsigned GAP_STEP = 4,
  parameter int unsigned GAP_W    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   tick,
  input  logic [NUM_W*COUNT-1:0] randoms,
  output logic                   rand_start,
  output logic                   spawn,
  output logic [TYPE_W-1:0]      spawn_type,
  output logic                   busy
);

  localparam int unsigned IDX_W = idx_width(COUNT);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(COUNT - 1);

  state_e                   state_q;
  logic [NUM_W*COUNT-1:0]   buf_q;
  logic [IDX_W-1:0]         idx_q;
  logic [IDX_W-1:0]         nxt_idx;

  logic                     cnt_clear;
  logic                     cnt_load;
  logic [GAP_W-1:0]         cnt_load_val;
  logic                     cnt_tick;
  logic                     expire;

  function automatic logic [GAP_W-1:0] gap_of(input logic [NUM_W-1:0] v);
    logic [GAP_W-1:0] hi;
    hi = GAP_W'(v[NUM_W-1:TYPE_W]);
    return GAP_W'(GAP_MIN) + hi * GAP_W'(GAP_STEP);
  endfunction

  assign nxt_idx = idx_q + IDX_W'(1);

  // Counter control. Slice 0 is decoded straight from randoms in LOAD because
  // the buffer only captures it on that same edge.
  always_comb begin
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_tick     = 1'b0;
    if (!enable) begin
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        StLoad: begin
          cnt_load     = 1'b1;
          cnt_load_val = gap_of(randoms[NUM_W-1:0]);
        end
        StWait:  cnt_tick = tick;
        StSpawn: begin
          if (idx_q != LastIdx) begin
            cnt_load     = 1'b1;
            cnt_load_val = gap_of(buf_q[nxt_idx*NUM_W +: NUM_W]);
          end
        end
        default: ;
      endcase
    end
  end

  obstacle_gap_counter #(
    .GAP_W (GAP_W)
  ) u_gap_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (cnt_tick),
    .expire   (expire)
  );

  // FSM with outputs registered for the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      idx_q      <= '0;
      rand_start <= 1'b0;
      spawn      <= 1'b0;
      spawn_type <= '0;
      busy       <= 1'b0;
    end else if (!enable) begin
      // Abort wins over any tick; spawn_type keeps the last spawned type.
      state_q    <= StIdle;
      buf_q      <= '0;
      idx_q      <= '0;
      rand_start <= 1'b0;
      spawn      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rand_start <= 1'b0;
      spawn      <= 1'b0;
      busy       <= 1'b1;
      unique case (state_q)
        StIdle: begin
          state_q    <= StReq;
          rand_start <= 1'b1;
        end
        StReq: state_q <= StLoad;
        StLoad: begin
          buf_q   <= randoms;
          idx_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (expire) begin
            state_q    <= StSpawn;
            spawn      <= 1'b1;
            spawn_type <= buf_q[idx_q*NUM_W +: TYPE_W];
          end
        end
        StSpawn: begin
          if (idx_q == LastIdx) begin
            state_q    <= StReq;
            rand_start <= 1'b1;
          end else begin
            idx_q   <= nxt_idx;
            state_q <= StWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler (NUM_W=4, COUNT=4, TYPE_W=2, GAP_MIN=8, GAP_STEP=4).
module tb_obstacle_scheduler;

  localparam int MAXC = 400;

  logic        clock   = 1'b0;
  logic        reset   = 1'b0;
  logic        enable  = 1'b0;
  logic        tick    = 1'b0;
  logic [15:0] randoms = '0;
  logic        rand_start;
  logic        spawn;
  logic [1:0]  spawn_type;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  // Timeline reference: cycle n is the interval after edge n; inputs of cycle n are
  // sampled by edge n+1.
  bit          tick_a[MAXC+4];
  logic [15:0] rnd_a[MAXC+4];
  bit          e_rs[MAXC+4];
  bit          e_sp[MAXC+4];
  logic [1:0]  e_ty[MAXC+4];

  typedef struct {
    logic [3:0] val;
    logic [1:0] ty;
    int         gap;
  } vec_t;

  vec_t tbl[8];

  obstacle_scheduler #(
    .NUM_W    (4),
    .COUNT    (4),
    .TYPE_W   (2),
    .GAP_MIN  (8),
    .GAP_STEP (4),
    .GAP_W    (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .tick       (tick),
    .randoms    (randoms),
    .rand_start (rand_start),
    .spawn      (spawn),
    .spawn_type (spawn_type),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    enable  = 1'b0;
    tick    = 1'b0;
    randoms = '0;
    reset   = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_rs(input string name);
    int n;
    n = 0;
    while (rand_start !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk(name, rand_start, 1);
  endtask

  // Counts cycles from the current one until spawn is seen (bounded).
  task automatic cycles_to_spawn(output int n, input bit scramble);
    n = 0;
    while (spawn !== 1'b1 && n < 60) begin
      if (scramble && n == 3) randoms = 16'h0000;
      step();
      n++;
    end
  endtask

  // Expected outputs from the batch rules: after a request at cycle c the batch is the
  // value present in cycle c+1, and each slice's gap counts ticks from the cycle after
  // load (or after the previous spawn's cycle) onwards.
  task automatic build_expect(input int n_cyc);
    int          c, w, m, cnt, g;
    bit          done;
    logic [15:0] v;
    logic [3:0]  s;
    for (int i = 0; i < MAXC + 4; i++) begin
      e_rs[i] = 1'b0;
      e_sp[i] = 1'b0;
      e_ty[i] = 2'd0;
    end
    c    = 1;
    done = 1'b0;
    while (!done && c < n_cyc) begin
      e_rs[c] = 1'b1;
      v = rnd_a[c+1];
      w = c + 2;
      for (int i = 0; i < 4 && !done; i++) begin
        s   = v[i*4 +: 4];
        g   = 8 + int'(s / 4) * 4;
        cnt = 0;
        m   = w;
        while (m < n_cyc && cnt < g) begin
          if (tick_a[m]) cnt++;
          if (cnt < g) m++;
        end
        if (cnt < g) begin
          done = 1'b1;
        end else begin
          e_sp[m+1] = 1'b1;
          e_ty[m+1] = s % 4;
          w = m + 2;
        end
      end
      c = w;
    end
    for (int i = 1; i < MAXC + 4; i++) begin
      if (!e_sp[i]) e_ty[i] = e_ty[i-1];
    end
  endtask

  task automatic run_model(input int n_cyc, input int dens, input int period, input bit fixed,
                           input logic [15:0] fval);
    logic [15:0] r;
    for (int i = 0; i < MAXC + 4; i++) begin
      if (period > 0) tick_a[i] = (i % period) == 0;
      else            tick_a[i] = $urandom_range(0, 99) < dens;
      r = 16'($urandom);
      rnd_a[i] = fixed ? fval : r;
    end
    build_expect(n_cyc);
    do_reset();
    for (int n = 0; n < n_cyc; n++) begin
      chk($sformatf("cycle %0d {rand_start,spawn,spawn_type,busy}", n),
          {rand_start, spawn, spawn_type, busy}, {e_rs[n], e_sp[n], e_ty[n], n > 0});
      enable  = 1'b1;
      tick    = tick_a[n];
      randoms = rnd_a[n];
      step();
    end
  endtask

  initial begin
    int          n;
    logic [15:0] tmp;
    bit          seen;

    tbl[0] = '{4'h0, 2'd0, 8};
    tbl[1] = '{4'h1, 2'd1, 8};
    tbl[2] = '{4'h5, 2'd1, 12};
    tbl[3] = '{4'hC, 2'd0, 20};
    tbl[4] = '{4'h3, 2'd3, 8};
    tbl[5] = '{4'hF, 2'd3, 20};
    tbl[6] = '{4'h6, 2'd2, 12};
    tbl[7] = '{4'hA, 2'd2, 16};

    // Reset held with enable high: everything stays zero.
    reset  = 1'b0;
    enable = 1'b1;
    tick   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("in_reset_outputs", {rand_start, spawn, spawn_type, busy}, 0);
    end
    reset = 1'b1;
    chk("release_rs0", rand_start, 0);
    step();
    chk("release_rs1", {rand_start, busy}, 2'b11);
    step();
    chk("release_rs2", rand_start, 0);

    // Per-value decode: one fresh batch per entry, tick every cycle.
    for (int i = 0; i < 8; i++) begin
      enable = 1'b0;
      step();
      step();
      tmp     = 16'($urandom);
      randoms = {tmp[15:4], tbl[i].val};
      enable  = 1'b1;
      tick    = 1'b1;
      wait_rs($sformatf("tbl%0d_req", i));
      cycles_to_spawn(n, 1'b0);
      chk($sformatf("tbl%0d_req_to_spawn", i), n, tbl[i].gap + 2);
      chk($sformatf("tbl%0d_type", i), spawn_type, tbl[i].ty);
      step();
      chk($sformatf("tbl%0d_pulse_width", i), spawn, 0);
    end

    // Reset mid-wait: immediate clear, no spawn while held, fresh request after.
    step();
    step();
    chk("type_held", spawn_type, 2);
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {rand_start, spawn, spawn_type, busy}, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen |= spawn | busy;
    end
    chk("reset_hold_quiet", seen, 0);
    reset = 1'b1;
    step();
    chk("post_reset_req", rand_start, 1);

    // Abort on the 5th tick of a gap-8 wait, then re-enable with a new batch.
    do_reset();
    randoms = 16'h0000;
    tick    = 1'b1;
    enable  = 1'b1;
    wait_rs("abort_req");
    for (int i = 0; i < 6; i++) step();
    enable = 1'b0;
    step();
    chk("abort_idle", {rand_start, spawn, busy}, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen |= spawn;
    end
    chk("abort_no_spawn", seen, 0);
    randoms = 16'hFFFF;
    enable  = 1'b1;
    wait_rs("reenable_req");
    cycles_to_spawn(n, 1'b1);
    chk("reenable_gap20_ignores_new_randoms", n, 22);
    chk("reenable_type", spawn_type, 3);

    // Timeline runs against the reference.
    run_model(300, 100, 0, 1'b0, 16'h0);
    run_model(300, 50, 0, 1'b0, 16'h0);
    run_model(300, 20, 0, 1'b0, 16'h0);
    run_model(200, 0, 3, 1'b1, 16'h3C50);
    run_model(120, 100, 0, 1'b1, 16'h3C51);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
